// File: rtl/tick_timer_pkg.sv
// ---------------------------------------------------------------------------
// tick_timer_pkg: shared state encoding and default widths for the tick timer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tick_timer_pkg;

  localparam int unsigned DEF_NCH = 4;
  localparam int unsigned DEF_W   = 16;
  localparam int unsigned DEF_DW  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } tt_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_tick_channel.sv
// ---------------------------------------------------------------------------
// prog_tick_channel: one start-delay / shadowed-modulus tick channel
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prog_tick_channel
  import tick_timer_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          oneshot_i,
  input  logic [W-1:0]  modulus_i,
  input  logic [DW-1:0] delay_i,
  output logic          max_tick_o,
  output logic          done_o,
  output logic          busy_o,
  output logic [W-1:0]  count_o
);

  tt_state_t     state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  m_q, m_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          os_q, os_d;
  logic          w_last;

  // Modulus 0 and 1 both mean "tick every enabled cycle"
  assign w_last = (m_q <= W'(1)) ? 1'b1 : (count_q == m_q - W'(1));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    m_d        = m_q;
    dly_d      = dly_q;
    os_d       = os_q;
    max_tick_o = 1'b0;
    done_o     = 1'b0;
    busy_o     = (state_q == DELAY) || (state_q == RUN);

    if (stop_i) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start_i) begin
      state_d = (delay_i != '0) ? DELAY : RUN;
      count_d = '0;
      m_d     = modulus_i;
      dly_d   = delay_i;
      os_d    = oneshot_i;
    end else begin
      case (state_q)
        IDLE: ;
        DELAY: begin
          // dly_q is always >= 1 while in DELAY
          if (enable_i) begin
            dly_d = dly_q - DW'(1);
            if (dly_q == DW'(1)) begin
              state_d = RUN;
              count_d = '0;
            end
          end
        end
        RUN: begin
          if (enable_i) begin
            if (w_last) begin
              max_tick_o = 1'b1;
              count_d    = '0;
              m_d        = modulus_i;
              if (os_q) state_d = DONE;
            end else begin
              count_d = count_q + W'(1);
            end
          end
        end
        DONE: begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      m_q     <= '0;
      dly_q   <= '0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      m_q     <= m_d;
      dly_q   <= dly_d;
      os_q    <= os_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/prog_tick_timer.sv
// ---------------------------------------------------------------------------
// prog_tick_timer: NCH independent programmable tick channels, packed I/O
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prog_tick_timer
  import tick_timer_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int W   = DEF_W,
  parameter int DW  = DEF_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    stop,
  input  logic [NCH-1:0]    oneshot,
  input  logic [NCH*W-1:0]  modulus,
  input  logic [NCH*DW-1:0] delay,
  output logic [NCH-1:0]    max_tick,
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    busy,
  output logic [NCH*W-1:0]  count
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    prog_tick_channel #(
      .W  (W),
      .DW (DW)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .enable_i   (enable),
      .start_i    (start[c]),
      .stop_i     (stop[c]),
      .oneshot_i  (oneshot[c]),
      .modulus_i  (modulus[c*W +: W]),
      .delay_i    (delay[c*DW +: DW]),
      .max_tick_o (max_tick[c]),
      .done_o     (done[c]),
      .busy_o     (busy[c]),
      .count_o    (count[c*W +: W])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_tick_timer.sv
// ---------------------------------------------------------------------------
// tb_prog_tick_timer: directed stimulus, per-cycle model comparison
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prog_tick_timer;

  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int DW  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [NCH-1:0]    start, stop, oneshot;
  logic [NCH*W-1:0]  modulus;
  logic [NCH*DW-1:0] delay;
  logic [NCH-1:0]    max_tick, done, busy;
  logic [NCH*W-1:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  prog_tick_timer #(.NCH(NCH), .W(W), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .stop     (stop),
    .oneshot  (oneshot),
    .modulus  (modulus),
    .delay    (delay),
    .max_tick (max_tick),
    .done     (done),
    .busy     (busy),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is idle, waiting out a delay, counting a period, or finishing
  localparam int M_IDLE = 0, M_WAIT = 1, M_CNT = 2, M_FIN = 3;
  int mode[NCH];
  int rem[NCH];
  int pos[NCH];
  int per[NCH];
  bit os[NCH];

  initial begin
    for (int c = 0; c < NCH; c++) begin
      mode[c] = M_IDLE; rem[c] = 0; pos[c] = 0; per[c] = 0; os[c] = 0;
    end
  end

  function automatic int eff_period(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        mode[c] = M_IDLE; rem[c] = 0; pos[c] = 0; per[c] = 0; os[c] = 0;
      end else if (stop[c]) begin
        mode[c] = M_IDLE; pos[c] = 0;
      end else if (start[c]) begin
        rem[c]  = int'(delay[c*DW +: DW]);
        per[c]  = int'(modulus[c*W +: W]);
        os[c]   = oneshot[c];
        pos[c]  = 0;
        mode[c] = (rem[c] > 0) ? M_WAIT : M_CNT;
      end else if (mode[c] == M_FIN) begin
        mode[c] = M_IDLE;
      end else if (enable && mode[c] == M_WAIT) begin
        rem[c] = rem[c] - 1;
        if (rem[c] == 0) begin mode[c] = M_CNT; pos[c] = 0; end
      end else if (enable && mode[c] == M_CNT) begin
        pos[c] = pos[c] + 1;
        if (pos[c] >= eff_period(per[c])) begin
          pos[c] = 0;
          per[c] = int'(modulus[c*W +: W]);
          if (os[c]) mode[c] = M_FIN;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NCH-1:0]   e_tick, e_done, e_busy;
    logic [NCH*W-1:0] e_cnt;
    for (int c = 0; c < NCH; c++) begin
      e_tick[c] = (mode[c] == M_CNT) && enable && !start[c] && !stop[c] &&
                  (pos[c] == eff_period(per[c]) - 1);
      e_done[c] = (mode[c] == M_FIN) && !start[c] && !stop[c];
      e_busy[c] = (mode[c] == M_WAIT) || (mode[c] == M_CNT);
      e_cnt[c*W +: W] = (mode[c] == M_CNT) ? W'(pos[c]) : '0;
    end
    chk("model_max_tick", 64'(max_tick), 64'(e_tick));
    chk("model_done",     64'(done),     64'(e_done));
    chk("model_busy",     64'(busy),     64'(e_busy));
    chk("model_count",    64'(count),    64'(e_cnt));
  end

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0;
    start = '0; stop = '0; oneshot = '0; modulus = '0; delay = '0;
    repeat (3) nc();
    #1;
    chk("reset_tick",  64'(max_tick), 64'd0);
    chk("reset_done",  64'(done),     64'd0);
    chk("reset_busy",  64'(busy),     64'd0);
    chk("reset_count", 64'(count),    64'd0);
    reset = 1'b0;
    nc();
    enable = 1'b1;

    // 1: periodic M=5, D=0 -> ticks at cycles 5, 10, 15
    start[0] = 1'b1; modulus[0*W +: W] = 16'd5;
    nc(); start[0] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      #1;
      chk("t1_tick",  64'(max_tick[0]), 64'((k % 5) == 0));
      chk("t1_busy",  64'(busy[0]), 64'd1);
      chk("t1_count", 64'(count[0*W +: W]), 64'((k - 1) % 5));
      nc();
    end
    stop[0] = 1'b1; nc(); stop[0] = 1'b0;

    // 2: one-shot M=3, D=4 -> busy 1..7, tick 7, done 8
    start[1] = 1'b1; oneshot[1] = 1'b1;
    modulus[1*W +: W] = 16'd3; delay[1*DW +: DW] = 16'd4;
    nc(); start[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk("t2_busy", 64'(busy[1]),     64'(k <= 7));
      chk("t2_tick", 64'(max_tick[1]), 64'(k == 7));
      chk("t2_done", 64'(done[1]),     64'(k == 8));
      nc();
    end

    // 3: periodic M=4 with enable alternating -> ticks at 7, 15, 23
    start[2] = 1'b1; modulus[2*W +: W] = 16'd4;
    nc(); start[2] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      enable = (k % 2) == 1;
      #1;
      chk("t3_tick", 64'(max_tick[2]), 64'((k % 8) == 7));
      nc();
    end
    enable = 1'b1;
    stop[2] = 1'b1; nc(); stop[2] = 1'b0;

    // 4: modulus 4 -> 2 in cycle 2: tick at 4, then every 2
    start[3] = 1'b1; modulus[3*W +: W] = 16'd4;
    nc(); start[3] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 2) modulus[3*W +: W] = 16'd2;
      #1;
      chk("t4_tick",  64'(max_tick[3]), 64'((k == 4) || (k > 4 && (k % 2) == 0)));
      chk("t4_count", 64'(count[3*W +: W]), 64'((k <= 4) ? (k - 1) : ((k - 5) % 2)));
      nc();
    end
    stop[3] = 1'b1; nc(); stop[3] = 1'b0;

    // 5: start+stop together aborts; start alone restarts the period
    start[0] = 1'b1; modulus[0*W +: W] = 16'd3;
    nc(); start[0] = 1'b0;
    nc();
    start[0] = 1'b1; stop[0] = 1'b1;
    nc(); start[0] = 1'b0; stop[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_abort_busy",  64'(busy[0]), 64'd0);
      chk("t5_abort_count", 64'(count[0*W +: W]), 64'd0);
      chk("t5_abort_done",  64'(done[0]), 64'd0);
      nc();
    end
    start[0] = 1'b1;
    nc(); start[0] = 1'b0;
    nc();
    start[0] = 1'b1;
    nc(); start[0] = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      #1;
      chk("t5_restart_tick",  64'(max_tick[0]), 64'((j % 3) == 0));
      chk("t5_restart_count", 64'(count[0*W +: W]), 64'((j - 1) % 3));
      nc();
    end
    stop[0] = 1'b1; nc(); stop[0] = 1'b0;

    // 6: all channels running, ch0 with M=0, then async reset mid-cycle
    oneshot = '0; delay = '0;
    modulus[0*W +: W] = 16'd0; modulus[1*W +: W] = 16'd2;
    modulus[2*W +: W] = 16'd3; modulus[3*W +: W] = 16'd7;
    start = '1;
    nc(); start = '0;
    for (int j = 1; j <= 5; j++) begin
      #1;
      chk("t6_m0_tick",  64'(max_tick[0]), 64'd1);
      chk("t6_m0_count", 64'(count[0*W +: W]), 64'd0);
      chk("t6_m2_tick",  64'(max_tick[1]), 64'((j % 2) == 0));
      nc();
    end
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_tick",  64'(max_tick), 64'd0);
    chk("t6_rst_done",  64'(done),     64'd0);
    chk("t6_rst_busy",  64'(busy),     64'd0);
    chk("t6_rst_count", 64'(count),    64'd0);
    nc();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6_post_busy", 64'(busy), 64'd0);
      nc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
